// File: rtl/cas_feeder.sv
// cas_feeder: streams a cassette tape image to a square-wave byte generator.
// The stream is a leader run, one sync byte, then the image bytes from memory.
// Playback can pause at byte boundaries (play low) and resume mid-image.
// Every output is registered.
module cas_feeder #(
  parameter int          ADDR_W      = 18,
  parameter logic [15:0] LEADER_LEN  = 16'd1024,
  parameter logic [7:0]  LEADER_BYTE = 8'h55,
  parameter logic [7:0]  SYNC_BYTE   = 8'h7F,
  parameter logic [7:0]  START_LEN   = 8'd64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              motor,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              gen_start,
  output logic [7:0]        gen_din,
  output logic              gen_extend,
  input  logic              gen_done,
  output logic              busy,
  output logic              eof,
  output logic [ADDR_W-1:0] pos
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  // Kind of byte currently being sent.
  localparam logic [1:0] K_LEADER = 2'd0;
  localparam logic [1:0] K_SYNC   = 2'd1;
  localparam logic [1:0] K_DATA   = 2'd2;

  // FETCH sub-steps: 0 = mem_rd out, 1 = read in flight, 2 = data arrives,
  // 3 = byte staged, waiting for the motor before START. Leader and sync
  // bytes need no memory read and are staged straight into step 3.
  localparam logic [1:0] F_RD    = 2'd0;
  localparam logic [1:0] F_LAT   = 2'd2;
  localparam logic [1:0] F_READY = 2'd3;

  logic [1:0]        state;
  logic [1:0]        kind;
  logic [1:0]        fstep;
  logic [7:0]        scnt;
  logic [15:0]       lcnt;
  logic              sync_done;

  logic [1:0]        cur_kind;
  logic [1:0]        nxt_kind;
  logic [1:0]        launch_kind;
  logic [ADDR_W-1:0] launch_addr;
  logic [ADDR_W-1:0] pos_inc;
  logic [16:0]       lcnt_inc;
  logic              last_byte;
  logic              idle_go;
  logic              wait_exit;
  logic              wait_go;
  logic              do_launch;

  assign pos_inc  = pos + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign lcnt_inc = {1'b0, lcnt} + 17'd1;

  // Byte to send when starting from IDLE. A nonzero position (or a sync
  // already sent) means a resume, so leader and sync are skipped.
  always_comb begin
    cur_kind = K_DATA;
    if (pos == '0 && !sync_done) begin
      if (lcnt < LEADER_LEN) cur_kind = K_LEADER;
      else                   cur_kind = K_SYNC;
    end
  end

  // Byte that follows the one finishing in WAIT.
  always_comb begin
    nxt_kind = K_DATA;
    if (kind == K_LEADER) begin
      if (lcnt_inc < {1'b0, LEADER_LEN}) nxt_kind = K_LEADER;
      else                               nxt_kind = K_SYNC;
    end
  end

  assign last_byte = (kind == K_DATA) && (pos_inc == len);
  assign idle_go   = (state == S_IDLE) && !rewind && play && motor &&
                     !eof && (len != '0);
  assign wait_exit = (state == S_WAIT) && gen_done;
  assign wait_go   = wait_exit && !last_byte && play;
  assign do_launch = idle_go || wait_go;

  // The launched data byte reads at the position it will occupy; after a
  // data byte that is the freshly incremented position.
  assign launch_kind = (state == S_IDLE) ? cur_kind : nxt_kind;
  assign launch_addr = (state == S_WAIT && kind == K_DATA) ? pos_inc : pos;

  // Main sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      kind       <= K_LEADER;
      fstep      <= F_RD;
      scnt       <= '0;
      lcnt       <= '0;
      sync_done  <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      gen_start  <= 1'b0;
      gen_din    <= '0;
      gen_extend <= 1'b0;
      busy       <= 1'b0;
      eof        <= 1'b0;
      pos        <= '0;
    end else begin
      mem_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          // Rewind wins over play; playback may start on the next cycle.
          if (rewind) begin
            pos       <= '0;
            eof       <= 1'b0;
            lcnt      <= '0;
            sync_done <= 1'b0;
          end else if (play && len == '0) begin
            eof <= 1'b1;
          end
        end
        S_FETCH: begin
          // Nothing has reached the generator yet, so a stop here is a
          // clean byte boundary; the byte is refetched on resume.
          if (!play) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            case (fstep)
              F_LAT: begin
                gen_din    <= mem_data;
                gen_extend <= 1'b1;
                fstep      <= F_READY;
              end
              F_READY: begin
                if (motor) begin
                  state     <= S_START;
                  gen_start <= 1'b1;
                  scnt      <= '0;
                end
              end
              default: fstep <= fstep + 2'd1;
            endcase
          end
        end
        S_START: begin
          // Motor is not consulted: a byte once started always completes.
          if (scnt == START_LEN - 8'd1) begin
            gen_start <= 1'b0;
            state     <= S_WAIT;
          end else begin
            scnt <= scnt + 8'd1;
          end
        end
        default: begin
          if (wait_exit) begin
            case (kind)
              K_LEADER: lcnt      <= lcnt + 16'd1;
              K_SYNC:   sync_done <= 1'b1;
              default:  pos       <= pos_inc;
            endcase
            if (last_byte) begin
              eof   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (!play) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
      endcase

      // Stage the next byte: data goes through a memory read, leader and
      // sync are loaded directly.
      if (do_launch) begin
        state <= S_FETCH;
        busy  <= 1'b1;
        kind  <= launch_kind;
        if (launch_kind == K_DATA) begin
          mem_addr <= launch_addr;
          mem_rd   <= 1'b1;
          fstep    <= F_RD;
        end else begin
          gen_din    <= (launch_kind == K_LEADER) ? LEADER_BYTE : SYNC_BYTE;
          gen_extend <= 1'b0;
          fstep      <= F_READY;
        end
      end
    end
  end

endmodule

// File: doc/cas_feeder.md
CAS_FEEDER -- requirements
Module: cas_feeder

Interface
REQ-001 Parameter ADDR_W, default 18: width of the tape-image address and length.
REQ-002 Parameter LEADER_LEN, default 16'd1024: number of leader bytes sent before sync.
REQ-003 Parameter LEADER_BYTE, default 8'h55: leader byte value.
REQ-004 Parameter SYNC_BYTE, default 8'h7F: sync byte value, sent once after the leader.
REQ-005 Parameter START_LEN, default 8'd64: clk cycles gen_start is held high per byte.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- play  in  1  playback request, level
- motor  in  1  cassette motor relay, 1 = running
- rewind  in  1  return to tape start, level
- len  in  ADDR_W  tape image length in bytes
- mem_addr  out  ADDR_W  tape image read address
- mem_rd  out  1  one-cycle read strobe
- mem_data  in  8  read data, valid exactly 2 cycles after mem_rd
- gen_start  out  1  start to square-wave generator
- gen_din  out  8  byte to generator
- gen_extend  out  1  1 = 9-bit framed data byte, 0 = raw 8-bit byte
- gen_done  in  1  generator byte-complete flag
- busy  out  1  playback in progress
- eof  out  1  whole image sent
- pos  out  ADDR_W  index of next data byte

Function
REQ-008 States SHALL be IDLE, FETCH, START, WAIT.
REQ-009 Stream order from pos==0: LEADER_LEN x LEADER_BYTE (extend=0), one SYNC_BYTE (extend=0), then mem[0..len-1] (extend=1).
REQ-010 Resume with pos!=0 SHALL skip leader and sync and continue at mem[pos].
REQ-011 IDLE -> FETCH when play=1, motor=1, eof=0, len!=0; busy=1 from the next cycle.
REQ-012 IDLE with play=1 and len==0 SHALL set eof=1 and stay in IDLE.
REQ-013 FETCH: mem_addr=pos; mem_rd high for exactly one cycle; mem_data latched into gen_din on the 2nd cycle after mem_rd; leader and sync bytes bypass FETCH.
REQ-014 START entered only with motor=1; while motor=0 the state SHALL hold before START with gen_start=0.
REQ-015 START: gen_start=1 for exactly START_LEN cycles; gen_din and gen_extend stable one cycle before gen_start rises until WAIT exits.
REQ-016 WAIT: gen_start=0; exit on the first cycle gen_done=1; no timeout.
REQ-017 Motor falling mid-byte (START/WAIT) SHALL NOT abort the byte.
REQ-018 Leader counter SHALL be 16 bits and count bytes completed in WAIT; sync follows when it reaches LEADER_LEN.
REQ-019 pos SHALL increment by 1 on WAIT exit for data bytes only.
REQ-020 After the data byte with pos==len-1 completes: eof=1, busy=0, IDLE.
REQ-021 play=0 SHALL stop at the next byte boundary (WAIT exit, or FETCH/START-hold); pos retained; busy=0.
REQ-022 rewind=1 in IDLE SHALL clear pos, eof and leader counter next cycle; rewind while busy is ignored.
REQ-023 play=1 and rewind=1 together in IDLE: rewind SHALL take priority; playback starts the following cycle if play remains 1.

Reset
REQ-024 On reset the block SHALL enter IDLE with mem_addr=0, mem_rd=0, gen_start=0, gen_din=0, gen_extend=0, busy=0, eof=0, pos=0, leader counter=0.
REQ-025 Reset SHALL take effect mid-byte and override play, motor and rewind.

Verification
REQ-026 LEADER_LEN=2, len=2, mem={A1,B2}, generator model raises done 100 cycles after start -> bytes 55,55,7F (extend 0), then A1,B2 (extend 1); eof=1, pos=2.
REQ-027 motor=0 during WAIT of byte 3 -> byte 3 completes, gen_start stays 0 until motor=1, then byte 4 starts.
REQ-028 play=0 after data byte 1 -> busy=0, pos=1; play=1 -> next byte is mem[1] with no leader.
REQ-029 len=0 with play=1 -> eof=1, no mem_rd, no gen_start.
REQ-030 reset asserted mid-START -> gen_start=0 next cycle, all outputs at reset values; rewind after eof -> eof=0, pos=0.
